// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch and load/store,
// with one outstanding transaction and starvation protection for fetch.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_ready,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                mem_req_valid,
  input  logic                mem_we,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_ready,
  output logic                mem_rvalid,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                bus_req_valid,
  input  logic                bus_req_ready,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_rsp_valid,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ISSUE    = 2'd1;
  localparam logic [1:0] WAIT_RSP = 2'd2;

  logic [1:0] state;
  logic       owner_if;
  logic       drop;
  logic [3:0] starve;
  logic       grant_if;
  logic       grant_mem;
  logic       flush_hit;

  // Fetch wins contention only once MEM has been granted STARVE_MAX times in a row over it.
  always_comb begin
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    if (state == IDLE) begin
      grant_if  = if_req_valid && (!mem_req_valid || (starve >= 4'(STARVE_MAX)));
      grant_mem = mem_req_valid && !grant_if;
    end
  end

  assign if_ready      = grant_if;
  assign mem_ready     = grant_mem;
  assign bus_req_valid = (state == ISSUE);
  assign flush_hit     = if_flush && owner_if && (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner_if   <= 1'b0;
      drop       <= 1'b0;
      starve     <= '0;
      bus_we     <= 1'b0;
      bus_wstrb  <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      if_rvalid  <= 1'b0;
      mem_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_if || grant_mem) begin
            state     <= ISSUE;
            owner_if  <= grant_if;
            drop      <= 1'b0;
            bus_we    <= grant_mem && mem_we;
            bus_wstrb <= grant_mem ? mem_wstrb : '0;
            bus_addr  <= grant_if ? if_addr : mem_addr;
            bus_wdata <= grant_mem ? mem_wdata : '0;
          end
          if (grant_if) begin
            starve <= '0;
          end else if (grant_mem && if_req_valid && (starve != 4'hF)) begin
            starve <= starve + 4'd1;
          end
        end
        ISSUE: begin
          if (flush_hit) drop <= 1'b1;
          if (bus_req_ready) state <= WAIT_RSP;
        end
        WAIT_RSP: begin
          if (flush_hit) drop <= 1'b1;
          if (bus_rsp_valid) begin
            state <= IDLE;
            // A flush arriving with the response must still suppress the pulse.
            if (owner_if) begin
              if_rdata  <= bus_rdata;
              if_rvalid <= !(drop || if_flush);
            end else begin
              mem_rdata  <= bus_rdata;
              mem_rvalid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed vector table, hand-written
// corner sequences, then random traffic against a transaction-level reference model.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req_valid;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_ready;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        mem_req_valid;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_we;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_rsp_valid;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_addr(if_addr), .if_flush(if_flush),
    .if_ready(if_ready), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .mem_req_valid(mem_req_valid), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_we(bus_we),
    .bus_wstrb(bus_wstrb), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ifv; logic [31:0] ifa; logic fl;
    logic mv; logic mwe; logic [3:0] mstb; logic [31:0] ma; logic [31:0] mwd;
    logic brdy; logic rsp; logic [31:0] brd;
    logic ir; logic mr; logic bv; logic [31:0] ba; logic bwe; logic [3:0] bstb;
    logic [31:0] bwd; logic irv; logic [31:0] ird; logic mrv; logic [31:0] mrd;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req_valid = 0; if_addr = 0; if_flush = 0;
    mem_req_valid = 0; mem_we = 0; mem_wstrb = 0; mem_addr = 0; mem_wdata = 0;
    bus_req_ready = 0; bus_rsp_valid = 0; bus_rdata = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".if_ready"}, 32'(if_ready), 0);
    check({tag, ".mem_ready"}, 32'(mem_ready), 0);
    check({tag, ".bus_req_valid"}, 32'(bus_req_valid), 0);
    check({tag, ".bus_addr"}, bus_addr, 0);
    check({tag, ".bus_wdata"}, bus_wdata, 0);
    check({tag, ".bus_we_wstrb"}, {27'd0, bus_we, bus_wstrb}, 0);
    check({tag, ".rvalids"}, {30'd0, if_rvalid, mem_rvalid}, 0);
    check({tag, ".if_rdata"}, if_rdata, 0);
    check({tag, ".mem_rdata"}, mem_rdata, 0);
  endtask

  // Reference model state: one pending transaction described by plain flags.
  logic        m_busy, m_issued, m_owner_if, m_drop, m_we;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata, m_ird, m_mrd;
  logic        m_irv, m_mrv;
  int          m_starve;

  task automatic model_reset();
    m_busy = 0; m_issued = 0; m_owner_if = 0; m_drop = 0; m_we = 0; m_wstrb = 0;
    m_addr = 0; m_wdata = 0; m_ird = 0; m_mrd = 0; m_irv = 0; m_mrv = 0; m_starve = 0;
  endtask

  initial begin
    logic want [6];
    logic got_if [$];
    logic eir, emr, ebv;
    logic if_pend, mem_pend;
    int   budget;

    tbl[0]  = '{1,32'h100,0, 0,0,4'h0,0,0, 1,0,0,             1,0,0,32'h0,0,0,0,          0,0,0,0};
    tbl[1]  = '{0,0,0, 0,0,0,0,0, 1,1,32'hBAD,                 0,0,1,32'h100,0,0,0,        0,0,0,0};
    tbl[2]  = '{0,0,0, 0,0,0,0,0, 1,1,32'h00500093,            0,0,0,32'h100,0,0,0,        0,0,0,0};
    tbl[3]  = '{0,0,0, 1,1,4'b0011,32'h2000,32'hDEADBEEF, 0,0,0, 0,1,0,32'h100,0,0,0,      1,32'h00500093,0,0};
    tbl[4]  = '{0,0,0, 0,0,0,0,0, 0,0,0,  0,0,1,32'h2000,1,4'b0011,32'hDEADBEEF, 0,32'h00500093,0,0};
    tbl[5]  = '{0,0,0, 0,0,0,0,0, 0,0,0,  0,0,1,32'h2000,1,4'b0011,32'hDEADBEEF, 0,32'h00500093,0,0};
    tbl[6]  = '{0,0,0, 0,0,0,0,0, 1,0,0,  0,0,1,32'h2000,1,4'b0011,32'hDEADBEEF, 0,32'h00500093,0,0};
    tbl[7]  = '{0,0,0, 0,0,0,0,0, 0,0,0,  0,0,0,32'h2000,1,4'b0011,32'hDEADBEEF, 0,32'h00500093,0,0};
    tbl[8]  = '{0,0,0, 0,0,0,0,0, 0,1,32'h55, 0,0,0,32'h2000,1,4'b0011,32'hDEADBEEF, 0,32'h00500093,0,0};
    tbl[9]  = '{0,0,0, 0,0,0,0,0, 0,1,32'h1234, 0,0,0,32'h2000,1,4'b0011,32'hDEADBEEF, 0,32'h00500093,1,32'h55};
    tbl[10] = '{0,0,0, 0,0,0,0,0, 0,0,0,  0,0,0,32'h2000,1,4'b0011,32'hDEADBEEF, 0,32'h00500093,0,32'h55};

    clear_inputs();
    reset = 1;
    tick(); tick();
    @(negedge clk);
    check_all_zero("reset");
    tick();
    reset = 0;

    // Single fetch, back-pressured store, stray responses in ISSUE and IDLE.
    for (int i = 0; i < 11; i++) begin
      if_req_valid = tbl[i].ifv; if_addr = tbl[i].ifa; if_flush = tbl[i].fl;
      mem_req_valid = tbl[i].mv; mem_we = tbl[i].mwe; mem_wstrb = tbl[i].mstb;
      mem_addr = tbl[i].ma; mem_wdata = tbl[i].mwd;
      bus_req_ready = tbl[i].brdy; bus_rsp_valid = tbl[i].rsp; bus_rdata = tbl[i].brd;
      @(negedge clk);
      check($sformatf("v%0d.if_ready", i), 32'(if_ready), 32'(tbl[i].ir));
      check($sformatf("v%0d.mem_ready", i), 32'(mem_ready), 32'(tbl[i].mr));
      check($sformatf("v%0d.bus_req_valid", i), 32'(bus_req_valid), 32'(tbl[i].bv));
      check($sformatf("v%0d.bus_addr", i), bus_addr, tbl[i].ba);
      check($sformatf("v%0d.bus_we", i), 32'(bus_we), 32'(tbl[i].bwe));
      check($sformatf("v%0d.bus_wstrb", i), 32'(bus_wstrb), 32'(tbl[i].bstb));
      check($sformatf("v%0d.bus_wdata", i), bus_wdata, tbl[i].bwd);
      check($sformatf("v%0d.if_rvalid", i), 32'(if_rvalid), 32'(tbl[i].irv));
      check($sformatf("v%0d.if_rdata", i), if_rdata, tbl[i].ird);
      check($sformatf("v%0d.mem_rvalid", i), 32'(mem_rvalid), 32'(tbl[i].mrv));
      check($sformatf("v%0d.mem_rdata", i), mem_rdata, tbl[i].mrd);
      tick();
    end
    clear_inputs();

    // Contention: both continuously valid, expect M,M,M,M,I,M with STARVE_MAX=4.
    want = '{0, 0, 0, 0, 1, 0};
    budget = 0;
    bus_req_ready = 1; bus_rsp_valid = 1;
    while (got_if.size() < 6 && budget < 40) begin
      if_req_valid = 1; if_addr = 32'h1000 + 32'(budget * 4);
      mem_req_valid = 1; mem_addr = 32'h3000 + 32'(budget * 4);
      @(negedge clk);
      if (if_ready && mem_ready) check("contention.both_ready", 1, 0);
      if (if_ready || mem_ready) got_if.push_back(if_ready);
      if (got_if.size() == 6) begin
        if_req_valid = 0; mem_req_valid = 0;
      end
      budget++;
      tick();
    end
    check("contention.grant_count", 32'(got_if.size()), 6);
    for (int i = 0; i < 6; i++)
      if (i < got_if.size()) check($sformatf("contention.grant%0d_is_if", i), 32'(got_if[i]), 32'(want[i]));
    tick(); tick();
    clear_inputs();

    // Flush coincident with the response: no pulse, IDLE next cycle, next fetch normal.
    if_req_valid = 1; if_addr = 32'h200; bus_req_ready = 1;
    @(negedge clk);
    check("flush.grant", 32'(if_ready), 1);
    tick();
    if_req_valid = 0;
    tick();
    if_flush = 1; bus_rsp_valid = 1; bus_rdata = 32'h777;
    tick();
    if_flush = 0; bus_rsp_valid = 0;
    if_req_valid = 1; if_addr = 32'h300;
    @(negedge clk);
    check("flush.no_rvalid", 32'(if_rvalid), 0);
    check("flush.regrant", 32'(if_ready), 1);
    tick();
    if_req_valid = 0;
    @(negedge clk);
    check("flush.new_addr", bus_addr, 32'h300);
    tick();
    bus_rsp_valid = 1; bus_rdata = 32'h00A00113;
    tick();
    bus_rsp_valid = 0;
    @(negedge clk);
    check("flush.next_rvalid", 32'(if_rvalid), 1);
    check("flush.next_rdata", if_rdata, 32'h00A00113);
    tick();
    clear_inputs();

    // Reset asserted while the bus request is being held.
    if_req_valid = 1; if_addr = 32'h400;
    tick();
    if_req_valid = 0;
    @(negedge clk);
    check("rst_mid.bus_req_valid_before", 32'(bus_req_valid), 1);
    #1 reset = 1;
    #1;
    check_all_zero("rst_mid");
    tick();
    reset = 0;
    bus_rsp_valid = 1; bus_rdata = 32'hCAFE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_mid.late_rsp%0d", i), {29'd0, bus_req_valid, if_rvalid, mem_rvalid}, 0);
      tick();
    end
    clear_inputs();

    // Random traffic against the reference model (DUT is in its post-reset state here).
    model_reset();
    if_pend = 0; mem_pend = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1; if_addr = $urandom & ~32'h3;
      end
      if (!mem_pend && $urandom_range(0, 2) == 0) begin
        mem_pend = 1; mem_addr = $urandom; mem_we = 1'($urandom);
        mem_wstrb = 4'($urandom); mem_wdata = $urandom;
      end
      if_req_valid = if_pend; mem_req_valid = mem_pend;
      if_flush = ($urandom_range(0, 5) == 0);
      bus_req_ready = ($urandom_range(0, 9) < 7);
      bus_rsp_valid = ($urandom_range(0, 9) < 4);
      bus_rdata = $urandom;

      eir = !m_busy && if_req_valid && (!mem_req_valid || m_starve >= 4);
      emr = !m_busy && mem_req_valid && !eir;
      ebv = m_busy && !m_issued;
      @(negedge clk);
      check("rnd.if_ready", 32'(if_ready), 32'(eir));
      check("rnd.mem_ready", 32'(mem_ready), 32'(emr));
      check("rnd.bus_req_valid", 32'(bus_req_valid), 32'(ebv));
      check("rnd.if_rvalid", 32'(if_rvalid), 32'(m_irv));
      check("rnd.mem_rvalid", 32'(mem_rvalid), 32'(m_mrv));
      check("rnd.if_rdata", if_rdata, m_ird);
      check("rnd.mem_rdata", mem_rdata, m_mrd);
      if (ebv) begin
        check("rnd.bus_addr", bus_addr, m_addr);
        check("rnd.bus_we", 32'(bus_we), 32'(m_we));
        check("rnd.bus_wstrb", 32'(bus_wstrb), 32'(m_wstrb));
        if (!m_owner_if) check("rnd.bus_wdata", bus_wdata, m_wdata);
      end

      m_irv = 0; m_mrv = 0;
      if (!m_busy) begin
        if (eir || emr) begin
          m_busy = 1; m_issued = 0; m_owner_if = eir; m_drop = 0;
          m_addr = eir ? if_addr : mem_addr;
          m_we = emr && mem_we;
          m_wstrb = emr ? mem_wstrb : 4'h0;
          m_wdata = mem_wdata;
          if (eir) m_starve = 0;
          else if (if_req_valid && m_starve < 15) m_starve++;
        end
      end else begin
        if (if_flush && m_owner_if) m_drop = 1;
        if (!m_issued) begin
          if (bus_req_ready) m_issued = 1;
        end else if (bus_rsp_valid) begin
          m_busy = 0;
          if (m_owner_if) begin m_ird = bus_rdata; m_irv = !m_drop; end
          else begin m_mrd = bus_rdata; m_mrv = 1; end
        end
      end
      if (eir) if_pend = 0;
      if (emr) mem_pend = 0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
